// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock signal of mem_port_arbiter.
//   slave  : arbiter view (requests and RAM read data in; done/rdata, RAM strobes, stalls out)
//   master : environment view (IF/MEM requesters, RAM model, pipeline controller)
// Signals:
//   if_req/if_addr/if_done/if_rdata                        instruction fetch requester
//   mem_req/mem_we/mem_addr/mem_size/mem_wdata/
//   mem_done/mem_rdata                                     load/store requester
//   ram_addr/ram_wdata/ram_we/ram_re/ram_rdata             byte-wide RAM port
//   stallreq_if/stallreq_mem                               stall requests to the pipeline
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [31:0]       if_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_size;
   logic [31:0]       mem_wdata;
   logic              mem_done;
   logic [31:0]       mem_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic              ram_we;
   logic              ram_re;
   logic [7:0]        ram_rdata;

   logic              stallreq_if;
   logic              stallreq_mem;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_rdata,
      output if_done, if_rdata, mem_done, mem_rdata, ram_addr, ram_wdata, ram_we, ram_re,
             stallreq_if, stallreq_mem
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_rdata,
      input  if_done, if_rdata, mem_done, mem_rdata, ram_addr, ram_wdata, ram_we, ram_re,
             stallreq_if, stallreq_mem
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch (IF) and load/store (MEM).
// MEM has fixed priority. Each 1/2/4-byte transaction is serialised into byte accesses on a
// registered RAM port; load bytes are assembled little-endian and returned zero-extended.
// Ports:
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (requesters, RAM port, stall requests)
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;       // 1 = MEM, 0 = IF
   logic              we_q, we_d;
   logic [1:0]        last_q, last_d;         // index of the final byte (N-1)
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              ram_we_q, ram_we_d;
   logic              ram_re_q, ram_re_d;
   logic              cap_vld_q, cap_vld_d;   // ram_rdata holds a byte this cycle
   logic [1:0]        cap_idx_q, cap_idx_d;   // which byte of the word it is
   logic [31:0]       asm_q, asm_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;

   logic [1:0]        mem_last;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;

   // Size 3 is treated as a word.
   always_comb begin
      mem_last = 2'd3;
      unique case (bus.mem_size)
         2'd0:    mem_last = 2'd0;
         2'd1:    mem_last = 2'd1;
         default: mem_last = 2'd3;
      endcase
   end

   // Fetches are always 4-byte reads.
   always_comb begin
      sel_we    = bus.mem_req & bus.mem_we;
      sel_addr  = bus.mem_req ? bus.mem_addr : bus.if_addr;
      sel_wdata = bus.mem_req ? bus.mem_wdata : 32'h0;
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      last_d      = last_q;
      wdata_d     = wdata_q;
      idx_d       = idx_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      ram_re_d    = 1'b0;
      // RAM returns data one cycle after the read strobe, so capture trails issue by a cycle.
      cap_vld_d   = ram_re_q;
      cap_idx_d   = idx_q;
      asm_d       = asm_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;

      if (cap_vld_q) begin
         asm_d[{cap_idx_q, 3'b000} +: 8] = bus.ram_rdata;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.mem_req || bus.if_req) begin
               owner_d     = bus.mem_req;
               we_d        = sel_we;
               last_d      = bus.mem_req ? mem_last : 2'd3;
               wdata_d     = sel_wdata;
               idx_d       = 2'd0;
               asm_d       = 32'h0;
               ram_addr_d  = sel_addr;
               ram_wdata_d = sel_wdata[7:0];
               ram_we_d    = sel_we;
               ram_re_d    = ~sel_we;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (idx_q == last_q) begin
               state_d = we_q ? StDone : StDrain;
            end else begin
               idx_d       = idx_q + 2'd1;
               ram_addr_d  = ram_addr_q + 1'b1;   // wraps modulo 2^ADDR_W
               ram_wdata_d = wdata_q[{idx_d, 3'b000} +: 8];
               ram_we_d    = we_q;
               ram_re_d    = ~we_q;
            end
         end
         StDrain: begin
            // asm_d already holds the final byte, so rdata is valid during DONE.
            if (owner_q) begin
               mem_rdata_d = asm_d;
            end else begin
               if_rdata_d = asm_d;
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         last_q      <= 2'd0;
         wdata_q     <= 32'h0;
         idx_q       <= 2'd0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 8'h0;
         ram_we_q    <= 1'b0;
         ram_re_q    <= 1'b0;
         cap_vld_q   <= 1'b0;
         cap_idx_q   <= 2'd0;
         asm_q       <= 32'h0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         last_q      <= last_d;
         wdata_q     <= wdata_d;
         idx_q       <= idx_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
         ram_re_q    <= ram_re_d;
         cap_vld_q   <= cap_vld_d;
         cap_idx_q   <= cap_idx_d;
         asm_q       <= asm_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus.ram_addr     = ram_addr_q;
   assign bus.ram_wdata    = ram_wdata_q;
   assign bus.ram_we       = ram_we_q;
   assign bus.ram_re       = ram_re_q;
   assign bus.if_done      = (state_q == StDone) && !owner_q;
   assign bus.mem_done     = (state_q == StDone) && owner_q;
   assign bus.if_rdata     = if_rdata_q;
   assign bus.mem_rdata    = mem_rdata_q;
   assign bus.stallreq_if  = bus.if_req && !bus.if_done;
   assign bus.stallreq_mem = bus.mem_req && !bus.mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte RAM (4 KiB, low 12 address bits).
// Cycle c0 is the cycle in which a request is first presented; E0 is the edge that ends c0.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   logic [7:0] ram [0:4095];

   mem_port_arbiter_if #(.ADDR_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered read: data for a ram_re cycle appears in the following cycle.
   always @(posedge clk) begin
      if (bus.ram_we) ram[bus.ram_addr[11:0]] <= bus.ram_wdata;
      if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr[11:0]];
   end

   task automatic idle_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_size  = 2'd0;
      bus.mem_wdata = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({bus.ram_we, bus.ram_re, bus.if_done, bus.mem_done} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_strobes: got %b want 0000",
                  {bus.ram_we, bus.ram_re, bus.if_done, bus.mem_done});
      end
      n_vec++;
      if (bus.ram_addr !== 32'h0 || bus.ram_wdata !== 8'h0) begin
         n_err++;
         $display("FAIL reset_port: got addr %h wdata %h want 0", bus.ram_addr, bus.ram_wdata);
      end
      n_vec++;
      if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rdata: got if %h mem %h want 0", bus.if_rdata, bus.mem_rdata);
      end
      n_vec++;
      if ({bus.stallreq_if, bus.stallreq_mem} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_stall: got %b want 00", {bus.stallreq_if, bus.stallreq_mem});
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_word_fetch();
      logic exp_re;
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
      @(posedge clk); #1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         exp_re = (c >= 1 && c <= 4);
         n_vec++;
         if (bus.ram_re !== exp_re || bus.ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_strobe c%0d: got re %b we %b want re %b we 0",
                     c, bus.ram_re, bus.ram_we, exp_re);
         end
         if (exp_re) begin
            n_vec++;
            if (bus.ram_addr !== 32'h100 + c - 1) begin
               n_err++;
               $display("FAIL fetch_addr c%0d: got %h want %h", c, bus.ram_addr, 32'h100 + c - 1);
            end
         end
         n_vec++;
         if (bus.if_done !== (c == 6) || bus.stallreq_if !== (c <= 5)) begin
            n_err++;
            $display("FAIL fetch_done c%0d: got done %b stall %b want %b %b",
                     c, bus.if_done, bus.stallreq_if, c == 6, c <= 5);
         end
      end
      n_vec++;
      if (bus.if_rdata !== 32'h44332211) begin
         n_err++;
         $display("FAIL fetch_rdata: got %h want 44332211", bus.if_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_half_store();
      logic       exp_we;
      logic [7:0] exp_b;
      ram[12'h201] = 8'hAA; ram[12'h202] = 8'h00; ram[12'h203] = 8'h00; ram[12'h204] = 8'h55;
      @(posedge clk); #1;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = 32'h202;
      bus.mem_size  = 2'd1;
      bus.mem_wdata = 32'h0000BEEF;
      for (int c = 0; c <= 3; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         exp_we = (c == 1 || c == 2);
         exp_b  = (c == 1) ? 8'hEF : 8'hBE;
         n_vec++;
         if (bus.ram_we !== exp_we || bus.ram_re !== 1'b0) begin
            n_err++;
            $display("FAIL store_strobe c%0d: got we %b re %b want we %b re 0",
                     c, bus.ram_we, bus.ram_re, exp_we);
         end
         if (exp_we) begin
            n_vec++;
            if (bus.ram_addr !== 32'h202 + c - 1 || bus.ram_wdata !== exp_b) begin
               n_err++;
               $display("FAIL store_byte c%0d: got %h@%h want %h@%h",
                        c, bus.ram_wdata, bus.ram_addr, exp_b, 32'h202 + c - 1);
            end
         end
         n_vec++;
         if (bus.mem_done !== (c == 3) || bus.stallreq_mem !== (c <= 2)) begin
            n_err++;
            $display("FAIL store_done c%0d: got done %b stall %b want %b %b",
                     c, bus.mem_done, bus.stallreq_mem, c == 3, c <= 2);
         end
      end
      n_vec++;
      if ({ram[12'h201], ram[12'h202], ram[12'h203], ram[12'h204]} !== 32'hAAEFBE55) begin
         n_err++;
         $display("FAIL store_ram: got %h want aaefbe55",
                  {ram[12'h201], ram[12'h202], ram[12'h203], ram[12'h204]});
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_byte_load();
      ram[12'h007] = 8'hF0; ram[12'h008] = 8'h99;
      @(posedge clk); #1;
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 32'h7;
      bus.mem_size = 2'd0;
      for (int c = 0; c <= 3; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         n_vec++;
         if (bus.ram_re !== (c == 1) || bus.mem_done !== (c == 3)) begin
            n_err++;
            $display("FAIL bload_ctl c%0d: got re %b done %b want %b %b",
                     c, bus.ram_re, bus.mem_done, c == 1, c == 3);
         end
      end
      n_vec++;
      if (bus.mem_rdata !== 32'h000000F0) begin
         n_err++;
         $display("FAIL bload_rdata: got %h want 000000f0", bus.mem_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_arbitration();
      logic        exp_re;
      logic [31:0] exp_a;
      ram[12'h040] = 8'hA1; ram[12'h041] = 8'hB2; ram[12'h042] = 8'hC3; ram[12'h043] = 8'hD4;
      ram[12'h000] = 8'h01; ram[12'h001] = 8'h02; ram[12'h002] = 8'h03; ram[12'h003] = 8'h04;
      @(posedge clk); #1;
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 32'h40;
      bus.mem_size = 2'd2;
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h0;
      for (int c = 0; c <= 13; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            if (c == 7) bus.mem_req = 1'b0;
         end
         @(negedge clk);
         exp_re = (c >= 1 && c <= 4) || (c >= 8 && c <= 11);
         exp_a  = (c <= 4) ? 32'h40 + c - 1 : 32'(c - 8);
         n_vec++;
         if (bus.ram_re !== exp_re) begin
            n_err++;
            $display("FAIL arb_re c%0d: got %b want %b", c, bus.ram_re, exp_re);
         end
         if (exp_re) begin
            n_vec++;
            if (bus.ram_addr !== exp_a) begin
               n_err++;
               $display("FAIL arb_addr c%0d: got %h want %h", c, bus.ram_addr, exp_a);
            end
         end
         n_vec++;
         if (bus.mem_done !== (c == 6) || bus.if_done !== (c == 13)) begin
            n_err++;
            $display("FAIL arb_done c%0d: got mem %b if %b want %b %b",
                     c, bus.mem_done, bus.if_done, c == 6, c == 13);
         end
         n_vec++;
         if (bus.stallreq_if !== (c <= 12) || bus.stallreq_mem !== (c <= 5)) begin
            n_err++;
            $display("FAIL arb_stall c%0d: got if %b mem %b want %b %b",
                     c, bus.stallreq_if, bus.stallreq_mem, c <= 12, c <= 5);
         end
         if (c == 6) begin
            n_vec++;
            if (bus.mem_rdata !== 32'hD4C3B2A1) begin
               n_err++;
               $display("FAIL arb_mem_rdata: got %h want d4c3b2a1", bus.mem_rdata);
            end
         end
      end
      n_vec++;
      if (bus.if_rdata !== 32'h04030201) begin
         n_err++;
         $display("FAIL arb_if_rdata: got %h want 04030201", bus.if_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      logic        exp_re;
      logic [31:0] exp_a;
      ram[12'h050] = 8'h5A; ram[12'h051] = 8'h6B; ram[12'h052] = 8'h7C; ram[12'h053] = 8'h8D;
      @(posedge clk); #1;
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 32'h50;
      bus.mem_size = 2'd2;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            if (c == 2) rst = 1'b1;
            if (c == 4) rst = 1'b0;
         end
         @(negedge clk);
         exp_re = (c == 1 || c == 2) || (c >= 5 && c <= 8);
         exp_a  = (c <= 2) ? 32'h50 + c - 1 : 32'h50 + c - 5;
         n_vec++;
         if (bus.ram_re !== exp_re || bus.ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_strobe c%0d: got re %b we %b want re %b we 0",
                     c, bus.ram_re, bus.ram_we, exp_re);
         end
         if (exp_re) begin
            n_vec++;
            if (bus.ram_addr !== exp_a) begin
               n_err++;
               $display("FAIL rmid_addr c%0d: got %h want %h", c, bus.ram_addr, exp_a);
            end
         end
         n_vec++;
         if (bus.mem_done !== (c == 10) || bus.stallreq_mem !== (c <= 9)) begin
            n_err++;
            $display("FAIL rmid_done c%0d: got done %b stall %b want %b %b",
                     c, bus.mem_done, bus.stallreq_mem, c == 10, c <= 9);
         end
         if (c == 3) begin
            n_vec++;
            if (bus.mem_rdata !== 32'h0) begin
               n_err++;
               $display("FAIL rmid_cleared: got %h want 0", bus.mem_rdata);
            end
         end
      end
      n_vec++;
      if (bus.mem_rdata !== 32'h8D7C6B5A) begin
         n_err++;
         $display("FAIL rmid_rdata: got %h want 8d7c6b5a", bus.mem_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_addr_wrap();
      logic [1:0]  sizes [2];
      logic [31:0] exp_a;
      sizes[0] = 2'd3;
      sizes[1] = 2'd2;
      ram[12'hFFE] = 8'h12; ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h56; ram[12'h001] = 8'h78;
      for (int s = 0; s < 2; s++) begin
         @(posedge clk); #1;
         bus.mem_req  = 1'b1;
         bus.mem_we   = 1'b0;
         bus.mem_addr = 32'hFFFF_FFFE;
         bus.mem_size = sizes[s];
         for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            exp_a = 32'hFFFF_FFFE + 32'(c - 1);
            if (c >= 1 && c <= 4) begin
               n_vec++;
               if (bus.ram_re !== 1'b1 || bus.ram_addr !== exp_a) begin
                  n_err++;
                  $display("FAIL wrap_addr sz%0d c%0d: got re %b addr %h want 1 %h",
                           sizes[s], c, bus.ram_re, bus.ram_addr, exp_a);
               end
            end
            n_vec++;
            if (bus.mem_done !== (c == 6)) begin
               n_err++;
               $display("FAIL wrap_done sz%0d c%0d: got %b want %b",
                        sizes[s], c, bus.mem_done, c == 6);
            end
         end
         n_vec++;
         if (bus.mem_rdata !== 32'h78563412) begin
            n_err++;
            $display("FAIL wrap_rdata sz%0d: got %h want 78563412", sizes[s], bus.mem_rdata);
         end
         @(posedge clk); #1;
         idle_inputs();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wd;
      logic        exp_stall;
      wd = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = 32'h300;
      bus.mem_size  = 2'd2;
      bus.mem_wdata = wd;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            if (c == 6) bus.mem_we = 1'b0;   // new request: load back the same word
         end
         @(negedge clk);
         n_vec++;
         if (bus.ram_we !== (c >= 1 && c <= 4) || bus.ram_re !== (c >= 7 && c <= 10)) begin
            n_err++;
            $display("FAIL b2b_strobe c%0d: got we %b re %b want %b %b", c, bus.ram_we,
                     bus.ram_re, c >= 1 && c <= 4, c >= 7 && c <= 10);
         end
         if (c >= 1 && c <= 4) begin
            n_vec++;
            if (bus.ram_wdata !== wd[8*(c-1) +: 8]) begin
               n_err++;
               $display("FAIL b2b_wdata c%0d: got %h want %h", c, bus.ram_wdata, wd[8*(c-1) +: 8]);
            end
         end
         exp_stall = !(c == 5 || c == 12);
         n_vec++;
         if (bus.mem_done !== (c == 5 || c == 12) || bus.stallreq_mem !== exp_stall) begin
            n_err++;
            $display("FAIL b2b_done c%0d: got done %b stall %b want %b %b",
                     c, bus.mem_done, bus.stallreq_mem, c == 5 || c == 12, exp_stall);
         end
      end
      n_vec++;
      if (bus.mem_rdata !== wd) begin
         n_err++;
         $display("FAIL b2b_rdata: got %h want %h", bus.mem_rdata, wd);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      idle_inputs();
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      test_reset();
      test_word_fetch();
      test_half_store();
      test_byte_load();
      test_arbitration();
      test_reset_mid();
      test_addr_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
